// File: rtl/crc_pkg.sv
// crc_pkg: shared definitions for the streaming CRC engine.
//   - crc_preset_t / presets: POLY/INIT/REFIN/REFOUT/XOROUT/RESIDUE sets
//     for CRC16-MODBUS, CRC16-CCITT-FALSE and CRC32-ISO.
//   - bit_rev(): reverse the low w bits of a 32-bit value.
//   - BPC_ALLOWED / bpc_legal(): supported bits-per-cycle settings.
package crc_pkg;

    typedef struct packed {
        logic [31:0] poly;
        logic [31:0] init;
        logic        refin;
        logic        refout;
        logic [31:0] xorout;
        logic [31:0] residue;
    } crc_preset_t;

    localparam crc_preset_t CRC16_MODBUS = '{
        poly: 32'h0000_8005, init: 32'h0000_FFFF, refin: 1'b1, refout: 1'b1,
        xorout: 32'h0000_0000, residue: 32'h0000_0000};

    localparam crc_preset_t CRC16_CCITT_FALSE = '{
        poly: 32'h0000_1021, init: 32'h0000_FFFF, refin: 1'b0, refout: 1'b0,
        xorout: 32'h0000_0000, residue: 32'h0000_0000};

    localparam crc_preset_t CRC32_ISO = '{
        poly: 32'h04C1_1DB7, init: 32'hFFFF_FFFF, refin: 1'b1, refout: 1'b1,
        xorout: 32'hFFFF_FFFF, residue: 32'hDEBB_20E3};

    localparam int unsigned BPC_ALLOWED [4] = '{1, 2, 4, 8};

    function automatic logic bpc_legal(input int unsigned bpc);
        logic ok;
        ok = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (BPC_ALLOWED[i] == bpc) ok = 1'b1;
        end
        return ok;
    endfunction

    // Bits above w in the result are zero.
    function automatic logic [31:0] bit_rev(input logic [31:0] v, input int unsigned w);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < w) r[5'(w - 1 - i)] = v[5'(i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_step.sv
// crc_step: combinational CRC advance by BPC unrolled bit steps.
//   crc_in  [WIDTH] : register value before the steps (byte already XORed in)
//   crc_out [WIDTH] : register value after BPC bit steps
// REFIN=1 shifts right against the reversed polynomial; REFIN=0 shifts left.
module crc_step
    import crc_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = 16'h8005,
    parameter bit               REFIN = 1'b1,
    parameter int unsigned      BPC   = 1
) (
    input  logic [WIDTH-1:0] crc_in,
    output logic [WIDTH-1:0] crc_out
);

    localparam logic [WIDTH-1:0] POLY_R = WIDTH'(bit_rev(32'(POLY), WIDTH));

    logic [WIDTH-1:0] acc;

    always_comb begin
        acc = crc_in;
        for (int unsigned i = 0; i < BPC; i++) begin
            if (REFIN) acc = acc[0] ? ((acc >> 1) ^ POLY_R) : (acc >> 1);
            else       acc = acc[WIDTH-1] ? ((acc << 1) ^ POLY) : (acc << 1);
        end
        crc_out = acc;
    end

endmodule

// File: rtl/crc_stream_engine.sv
// crc_stream_engine: parametrised streaming CRC with valid/ready byte input.
//   clk, rst_n     : clock, synchronous active-low reset
//   init           : reload INIT, abort any byte in progress
//   s_data/s_valid/s_last/s_ready : byte stream handshake, s_last marks frame end
//   busy           : a byte is still being stepped
//   crc_out        : output-transformed CRC, stable while busy=0
//   crc_valid      : one-cycle pulse when the frame's last byte completes
//   match          : raw register equals RESIDUE
module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int unsigned      WIDTH   = 16,
    parameter logic [WIDTH-1:0] POLY    = 16'h8005,
    parameter logic [WIDTH-1:0] INIT    = 16'hFFFF,
    parameter bit               REFIN   = 1'b1,
    parameter bit               REFOUT  = 1'b1,
    parameter logic [WIDTH-1:0] XOROUT  = 16'h0000,
    parameter logic [WIDTH-1:0] RESIDUE = 16'h0000,
    parameter int unsigned      BPC     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic             busy,
    output logic [WIDTH-1:0] crc_out,
    output logic             crc_valid,
    output logic             match
);

    localparam int unsigned STEPS    = 8 / BPC;
    localparam logic [2:0]  CNT_LOAD = 3'(STEPS - 1);

    logic [WIDTH-1:0] crc;
    logic [2:0]       cnt;
    logic             last_q;
    logic             accept;
    logic [WIDTH-1:0] byte_x;
    logic [WIDTH-1:0] step_in;
    logic [WIDTH-1:0] step_out;
    logic [WIDTH-1:0] crc_rev;

    assign s_ready = (cnt == 3'd0) && !init;
    assign busy    = (cnt != 3'd0);
    assign accept  = s_valid && s_ready;

    // Byte lands in the low bits when reflected, in the top byte otherwise.
    assign byte_x  = REFIN ? WIDTH'(s_data) : (WIDTH'(s_data) << (WIDTH - 8));
    assign step_in = accept ? (crc ^ byte_x) : crc;

    crc_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .REFIN (REFIN),
        .BPC   (BPC)
    ) u_step (
        .crc_in  (step_in),
        .crc_out (step_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc       <= INIT;
            cnt       <= '0;
            last_q    <= 1'b0;
            crc_valid <= 1'b0;
        end else if (init) begin
            crc       <= INIT;
            cnt       <= '0;
            last_q    <= 1'b0;
            crc_valid <= 1'b0;
        end else begin
            crc_valid <= 1'b0;
            if (accept) begin
                crc    <= step_out;
                cnt    <= CNT_LOAD;
                last_q <= s_last;
                // Single-cycle bytes finish on the accept edge itself.
                if (STEPS == 1) crc_valid <= s_last;
            end else if (cnt != 3'd0) begin
                crc <= step_out;
                cnt <= cnt - 3'd1;
                if (cnt == 3'd1) crc_valid <= last_q;
            end
        end
    end

    assign crc_rev = WIDTH'(bit_rev(32'(crc), WIDTH));
    assign crc_out = ((REFOUT != REFIN) ? crc_rev : crc) ^ XOROUT;
    assign match   = (crc == RESIDUE);

endmodule

// File: tb/tb_crc_stream_engine.sv
module tb_crc_stream_engine;

    logic       clk = 1'b0;
    logic       rst_n, init;
    logic [7:0] s_data;
    logic       s_valid, s_last;

    logic        rdy0, bsy0, val0, mat0;
    logic [15:0] out0;
    logic        rdy1, bsy1, val1, mat1;
    logic [15:0] out1;
    logic        rdy2, bsy2, val2, mat2;
    logic [31:0] out2;

    crc_stream_engine #(
        .WIDTH(16), .POLY(16'h8005), .INIT(16'hFFFF), .REFIN(1'b1), .REFOUT(1'b1),
        .XOROUT(16'h0000), .RESIDUE(16'h0000), .BPC(1)
    ) dut_modbus (
        .clk(clk), .rst_n(rst_n), .init(init), .s_data(s_data), .s_valid(s_valid),
        .s_last(s_last), .s_ready(rdy0), .busy(bsy0), .crc_out(out0),
        .crc_valid(val0), .match(mat0)
    );

    crc_stream_engine #(
        .WIDTH(16), .POLY(16'h1021), .INIT(16'hFFFF), .REFIN(1'b0), .REFOUT(1'b0),
        .XOROUT(16'h0000), .RESIDUE(16'h0000), .BPC(4)
    ) dut_ccitt (
        .clk(clk), .rst_n(rst_n), .init(init), .s_data(s_data), .s_valid(s_valid),
        .s_last(s_last), .s_ready(rdy1), .busy(bsy1), .crc_out(out1),
        .crc_valid(val1), .match(mat1)
    );

    crc_stream_engine #(
        .WIDTH(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .REFIN(1'b1), .REFOUT(1'b1),
        .XOROUT(32'hFFFFFFFF), .RESIDUE(32'hDEBB20E3), .BPC(8)
    ) dut_crc32 (
        .clk(clk), .rst_n(rst_n), .init(init), .s_data(s_data), .s_valid(s_valid),
        .s_last(s_last), .s_ready(rdy2), .busy(bsy2), .crc_out(out2),
        .crc_valid(val2), .match(mat2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int sel   = 0;

    logic        o_ready, o_busy, o_valid, o_match;
    logic [31:0] o_out;

    always_comb begin
        case (sel)
            0:       begin o_ready = rdy0; o_busy = bsy0; o_valid = val0; o_match = mat0; o_out = {16'h0, out0}; end
            1:       begin o_ready = rdy1; o_busy = bsy1; o_valid = val1; o_match = mat1; o_out = {16'h0, out1}; end
            default: begin o_ready = rdy2; o_busy = bsy2; o_valid = val2; o_match = mat2; o_out = out2; end
        endcase
    end

    // Per-instance configuration for the reference model.
    int          cfg_w    [3] = '{16, 16, 32};
    logic [31:0] cfg_poly [3] = '{32'h8005, 32'h1021, 32'h04C11DB7};
    logic [31:0] cfg_init [3] = '{32'hFFFF, 32'hFFFF, 32'hFFFFFFFF};
    bit          cfg_ref  [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] cfg_xor  [3] = '{32'h0, 32'h0, 32'hFFFFFFFF};
    logic [31:0] cfg_res  [3] = '{32'h0, 32'h0, 32'hDEBB20E3};
    int          cfg_bpc  [3] = '{1, 4, 8};

    typedef logic [7:0] byte_q_t[$];
    byte_q_t check_str;

    function automatic logic [31:0] rev_n(input logic [31:0] v, input int w);
        logic [31:0] r = '0;
        for (int i = 0; i < w; i++) r[w-1-i] = v[i];
        return r;
    endfunction

    // Textbook MSB-first polynomial division on the message bits; reflection
    // handled by reversing input bytes and the register at the boundaries.
    function automatic logic [31:0] model_norm(input byte_q_t d, input int s);
        logic [63:0] mask, r;
        logic [7:0]  b;
        bit          fb;
        mask = (64'd1 << cfg_w[s]) - 64'd1;
        r = {32'h0, cfg_ref[s] ? rev_n(cfg_init[s], cfg_w[s]) : cfg_init[s]};
        foreach (d[k]) begin
            b = cfg_ref[s] ? 8'(rev_n({24'h0, d[k]}, 8)) : d[k];
            for (int i = 7; i >= 0; i--) begin
                fb = r[cfg_w[s]-1] ^ b[i];
                r  = (r << 1) & mask;
                if (fb) r = r ^ {32'h0, cfg_poly[s]};
            end
        end
        return r[31:0];
    endfunction

    function automatic logic [31:0] model_out(input byte_q_t d, input int s);
        logic [31:0] r = model_norm(d, s);
        return (cfg_ref[s] ? rev_n(r, cfg_w[s]) : r) ^ cfg_xor[s];
    endfunction

    function automatic logic model_match(input byte_q_t d, input int s);
        logic [31:0] r = model_norm(d, s);
        return (cfg_ref[s] ? rev_n(r, cfg_w[s]) : r) == cfg_res[s];
    endfunction

    // Results of the last stream() call.
    int r_acc, r_vcyc, r_vcnt, r_nr, r_busy;

    task automatic stream(input byte_q_t d, input bit gaps, input bit mark_last);
        int idx = 0;
        int guard = 0;
        bit held = 1'b0;
        bit done = 1'b0;
        r_acc = -1; r_vcyc = -1; r_vcnt = 0; r_nr = 0; r_busy = 0;
        while (!done && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (o_valid) begin r_vcnt++; r_vcyc = cyc; end
            if (r_acc >= 0 && o_busy) r_busy++;
            if (idx < d.size()) begin
                if (!held) begin
                    if (gaps && $urandom_range(0, 2) == 0) begin
                        s_valid = 1'b0; s_last = 1'b0;
                    end else begin
                        s_valid = 1'b1; s_data = d[idx];
                        s_last = mark_last && (idx == d.size() - 1);
                        held = 1'b1;
                    end
                end
                if (held && o_ready) begin
                    if (idx == 0) r_acc = cyc + 1;
                    idx++;
                    held = 1'b0;
                end else if (held) begin
                    r_nr++;
                end
            end else begin
                s_valid = 1'b0; s_last = 1'b0;
                if (mark_last ? (r_vcnt > 0) : !o_busy) done = 1'b1;
            end
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL stream_timeout sel=%0d accepted=%0d of %0d", sel, idx, d.size());
        end
    endtask

    task automatic pulse_init();
        @(negedge clk);
        init = 1'b1; s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        init = 1'b0;
    endtask

    // Counts crc_valid pulses over a few idle cycles; none are expected.
    task automatic watch_quiet(input int n, output int extra);
        extra = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (o_valid) extra++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; init = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (out0 !== 16'hFFFF) begin bad++; $display("FAIL reset_out_modbus got=%h exp=ffff", out0); end
        total++; if (out1 !== 16'hFFFF) begin bad++; $display("FAIL reset_out_ccitt got=%h exp=ffff", out1); end
        total++; if (out2 !== 32'h0) begin bad++; $display("FAIL reset_out_crc32 got=%h exp=00000000", out2); end
        total++; if ({bsy0, bsy1, bsy2, val0, val1, val2} !== 6'b0) begin
            bad++; $display("FAIL reset_busy_valid got=%b exp=000000", {bsy0, bsy1, bsy2, val0, val1, val2});
        end
        total++; if ({rdy0, rdy1, rdy2} !== 3'b111) begin bad++; $display("FAIL reset_ready got=%b exp=111", {rdy0, rdy1, rdy2}); end
    endtask

    task automatic test_modbus();
        int extra;
        sel = 0;
        pulse_init();
        stream(check_str, 1'b0, 1'b1);
        watch_quiet(5, extra);
        total++; if (o_out[15:0] !== 16'h4B37) begin bad++; $display("FAIL modbus_crc got=%h exp=4b37", o_out[15:0]); end
        total++; if (o_out !== model_out(check_str, 0)) begin bad++; $display("FAIL modbus_model got=%h exp=%h", o_out, model_out(check_str, 0)); end
        total++; if (r_vcnt + extra !== 1) begin bad++; $display("FAIL modbus_valid_pulses got=%0d exp=1", r_vcnt + extra); end
        total++; if (r_vcyc - r_acc + 1 !== 72) begin bad++; $display("FAIL modbus_latency got=%0d exp=72", r_vcyc - r_acc + 1); end
        total++; if (r_busy !== 63) begin bad++; $display("FAIL modbus_busy_cycles got=%0d exp=63", r_busy); end
    endtask

    task automatic test_residue();
        byte_q_t tail = '{8'h37, 8'h4B};
        byte_q_t all;
        sel = 0;
        pulse_init();
        stream(check_str, 1'b0, 1'b1);
        stream(tail, 1'b0, 1'b1);
        all = {check_str, tail};
        total++; if (o_out[15:0] !== 16'h0000) begin bad++; $display("FAIL residue_raw got=%h exp=0000", o_out[15:0]); end
        total++; if (o_match !== 1'b1 || model_match(all, 0) !== 1'b1) begin
            bad++; $display("FAIL residue_match got=%b exp=1", o_match);
        end
    endtask

    task automatic test_ccitt_bpc4();
        sel = 1;
        pulse_init();
        stream(check_str, 1'b0, 1'b1);
        total++; if (o_out[15:0] !== 16'h29B1) begin bad++; $display("FAIL ccitt_crc got=%h exp=29b1", o_out[15:0]); end
        total++; if (r_busy !== 9) begin bad++; $display("FAIL ccitt_not_ready_cycles got=%0d exp=9", r_busy); end
        total++; if (r_vcyc - r_acc + 1 !== 18) begin bad++; $display("FAIL ccitt_latency got=%0d exp=18", r_vcyc - r_acc + 1); end
    endtask

    task automatic test_crc32_bpc8();
        sel = 2;
        pulse_init();
        stream(check_str, 1'b0, 1'b1);
        total++; if (o_out !== 32'hCBF43926) begin bad++; $display("FAIL crc32_crc got=%h exp=cbf43926", o_out); end
        total++; if (r_vcyc - r_acc !== 8 || r_nr !== 0) begin
            bad++; $display("FAIL crc32_one_per_cycle got=%0d stalls=%0d exp=8 stalls=0", r_vcyc - r_acc, r_nr);
        end
    endtask

    task automatic test_backpressure();
        sel = 0;
        pulse_init();
        stream(check_str, 1'b1, 1'b1);
        total++; if (o_out[15:0] !== 16'h4B37) begin bad++; $display("FAIL backpressure_crc got=%h exp=4b37", o_out[15:0]); end
        total++; if (r_nr < 8) begin bad++; $display("FAIL backpressure_stalls got=%0d exp>=8", r_nr); end
    endtask

    // kind 0 aborts with init, kind 1 with rst_n, during step 3 of byte 5.
    task automatic test_abort(input int kind);
        byte_q_t head;
        int extra;
        sel = 0;
        for (int i = 0; i < 4; i++) head.push_back(check_str[i]);
        pulse_init();
        stream(head, 1'b0, 1'b0);
        @(negedge clk);
        s_data = check_str[4]; s_valid = 1'b1; s_last = 1'b0;
        @(negedge clk);
        s_valid = 1'b0;
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL abort%0d_busy_before got=%b exp=1", kind, o_busy); end
        @(negedge clk);
        if (kind == 0) init = 1'b1; else rst_n = 1'b0;
        #1;
        if (kind == 0) begin
            total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL abort_ready_during_init got=%b exp=0", o_ready); end
        end
        @(negedge clk);
        init = 1'b0; rst_n = 1'b1;
        total++; if (o_out[15:0] !== 16'hFFFF || o_busy !== 1'b0 || o_valid !== 1'b0) begin
            bad++; $display("FAIL abort%0d_state got out=%h busy=%b valid=%b exp out=ffff busy=0 valid=0",
                            kind, o_out[15:0], o_busy, o_valid);
        end
        watch_quiet(10, extra);
        total++; if (extra !== 0 || o_busy !== 1'b0) begin bad++; $display("FAIL abort%0d_quiet got=%0d exp=0", kind, extra); end
        stream(check_str, 1'b0, 1'b1);
        total++; if (o_out[15:0] !== 16'h4B37) begin bad++; $display("FAIL abort%0d_restart got=%h exp=4b37", kind, o_out[15:0]); end
    endtask

    task automatic test_random();
        byte_q_t f1, f2, all;
        for (int s = 0; s < 3; s++) begin
            for (int rep = 0; rep < 3; rep++) begin
                sel = s;
                f1.delete(); f2.delete();
                for (int i = 0; i < $urandom_range(1, 10); i++) f1.push_back(8'($urandom));
                for (int i = 0; i < $urandom_range(1, 6); i++) f2.push_back(8'($urandom));
                pulse_init();
                stream(f1, 1'b1, 1'b1);
                total++; if (o_out !== model_out(f1, s)) begin
                    bad++; $display("FAIL random_frame sel=%0d got=%h exp=%h", s, o_out, model_out(f1, s));
                end
                // Second frame continues from the first without init.
                stream(f2, 1'b1, 1'b1);
                all = {f1, f2};
                total++; if (o_out !== model_out(all, s) || o_match !== model_match(all, s)) begin
                    bad++; $display("FAIL random_continue sel=%0d got=%h/%b exp=%h/%b",
                                    s, o_out, o_match, model_out(all, s), model_match(all, s));
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 9; i++) check_str.push_back(8'h31 + 8'(i));
        test_reset();
        test_modbus();
        test_residue();
        test_ccitt_bpc4();
        test_crc32_bpc8();
        test_backpressure();
        test_abort(0);
        test_abort(1);
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crc_stream_engine.md
# crc_stream_engine

Parametrised streaming CRC engine, next generation of the team's bit-serial CRC16-MODBUS engine. Width, polynomial, init, reflection, final XOR and bits-per-cycle are compile-time parameters, and bytes arrive over a valid/ready handshake with a frame-end marker. It sits beside the LoraLite protocol logic as a peripheral datapath for frame CRC generation and check-residue verification.

## Interface
- WIDTH, 16: CRC width, 8..32.
- POLY, 16'h8005: polynomial, normal (MSB-first) notation, WIDTH bits.
- INIT, 16'hFFFF: register value after reset or `init`.
- REFIN, 1: 1 = LSB-first (reflected) processing; 0 = MSB-first.
- REFOUT, 1: bit-reverse the result when REFOUT != REFIN.
- XOROUT, 16'h0000: XOR applied to the output.
- RESIDUE, 16'h0000: raw register value that indicates a good frame (data + appended CRC).
- BPC, 1: bits processed per cycle, one of 1, 2, 4, 8.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- init  in  1  reload the register with INIT and abort any byte in progress.
- s_data  in  8  input byte.
- s_valid  in  1  byte valid.
- s_last  in  1  byte is the last byte of the frame; qualified with s_valid.
- s_ready  out  1  engine can accept a byte.
- busy  out  1  byte in progress.
- crc_out  out  WIDTH  output-transformed CRC; stable while busy=0.
- crc_valid  out  1  one-cycle pulse when a frame's last byte completes.
- match  out  1  raw register == RESIDUE.

## Operation
- Internal register `crc` and step counter `cnt` (0 = idle, range 0..8/BPC-1).
- Reflected mode (REFIN=1): the byte is XORed into crc[7:0]. Each bit step is `crc = crc[0] ? (crc>>1)^rev(POLY) : crc>>1`.
- Normal mode (REFIN=0): the byte is XORed into crc[WIDTH-1:WIDTH-8]. Each bit step is `crc = crc[WIDTH-1] ? (crc<<1)^POLY : crc<<1`. All arithmetic is WIDTH bits and the shifted-out bit is dropped.
- Each cycle applies BPC bit steps.
- Accept happens when s_valid && s_ready. On the accept edge the byte XOR is applied and the first BPC steps are performed. cnt is then loaded with 8/BPC-1, and s_last is latched into `last_q`.
- While cnt != 0: BPC steps per cycle, cnt decrements.
- On the edge where the final step of a byte with last_q=1 completes, crc_valid is registered high for one cycle.
- s_ready = (cnt == 0) && !init. busy = (cnt != 0).
- crc_out = (REFOUT != REFIN ? rev(crc) : crc) ^ XOROUT. It is combinational from the register.
- match is combinational on the raw crc. Callers sample it when busy=0.
- Priority order: rst_n, then init, then accept, then step.
- init mid-byte: crc=INIT, cnt=0, last_q=0, and no crc_valid is produced.
- s_valid while s_ready=0: the byte is not accepted, and the source must hold it (standard handshake). This differs from the legacy engine, which dropped such bytes silently.
- init does not clear the frame automatically after crc_valid. The next frame continues from the current value unless init is pulsed.

## Timing
- Reset values: crc=INIT, cnt=0, busy=0, crc_valid=0, last_q=0. crc_out = transform(INIT) (16'hFFFF for the defaults). s_ready is don't-care while rst_n is low.
- Per-byte occupancy is 8/BPC cycles: 8 cycles at BPC=1, 1 cycle at BPC=8. At BPC=8 s_ready stays high, giving one byte per cycle.
- A byte accepted at edge t has its result in crc at edge t+8/BPC-1. s_ready returns high in the cycle after that edge. Back-to-back accept then needs no dead cycle.
- crc_valid goes high in the cycle after the last byte's final step, coincident with busy=0 and the final crc_out.

## Structure
- Package `crc_pkg` holds:
  - preset localparams (CRC16_MODBUS, CRC16_CCITT_FALSE, CRC32_ISO) as POLY/INIT/REFIN/REFOUT/XOROUT/RESIDUE sets;
  - function `bit_rev(WIDTH)`;
  - the allowed BPC values.
- Sub-module `crc_step`: purely combinational, parameterised by WIDTH/POLY/REFIN/BPC. It maps crc_in to crc_out over BPC unrolled bit steps. It is instantiated once; the top module holds the registers, counter and handshake.
- Target size: about 200 lines total.

## Test plan
- MODBUS defaults, BPC=1: init, then stream "123456789" (0x31..0x39, last on 0x39). Required: crc_out=0x4B37, crc_valid pulses once, 72 cycles from first accept to crc_valid.
- Same stream, then 0x37, 0x4B with last. Required: raw crc=0x0000, match=1.
- CRC16_CCITT_FALSE preset (POLY 0x1021, INIT 0xFFFF, no reflection), BPC=4, "123456789". Required: crc_out=0x29B1, s_ready low 1 cycle per byte.
- CRC32_ISO preset, BPC=8, "123456789" with s_valid held high. Required: one accept per cycle, crc_out=0xCBF43926.
- Backpressure: s_valid held during busy at BPC=1. Required: no duplicate or lost bytes; result still 0x4B37.
- Abort: init asserted at step 3 of byte 5, and separately rst_n low mid-byte. Required: crc_out=0xFFFF next cycle, busy=0, no crc_valid; a restarted frame gives 0x4B37.
